fetch_stage: RTL and testbench

Instruction fetch stage of the riscv32i core: owns the program counter, issues word reads to instruction memory and delivers {pc, instr} pairs to decode over a valid/ready handshake. A 2-entry buffer absorbs decode back-pressure, and execute can redirect the PC on taken branches and jumps. Sits between instruction memory and the decode stage.

---
 rtl/riscv_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 68 ++++++
 rtl/fetch_stage.sv | 101 ++++++++++
 tb/tb_fetch_stage.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types and constants for the riscv32i front end.
//   XLEN          : architectural register / address width
//   INSTR_NOP     : canonical NOP (addi x0, x0, 0)
//   fetch_entry_t : {pc, instr} pair handed from fetch to decode
package riscv_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned FIFO_CNT_W = 2;

  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry FIFO of fetch_entry_t between the fetch PC logic and decode.
//   clk, rst      : clock, asynchronous active-high reset
//   push_i/data_i : write one entry (caller guarantees not full)
//   pop_i         : drop the head entry (caller guarantees not empty)
//   flush_i       : discard all entries; wins over push/pop
//   count_o       : number of valid entries, 0..2
//   head_o        : oldest entry (meaningful only when count_o != 0)
module fetch_fifo
  import riscv_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  fetch_entry_t          data_i,
  input  logic                  pop_i,
  input  logic                  flush_i,
  output logic [FIFO_CNT_W-1:0] count_o,
  output fetch_entry_t          head_o
);

  fetch_entry_t              mem_q [2];
  logic                      wr_ptr_q, wr_ptr_d;
  logic                      rd_ptr_q, rd_ptr_d;
  logic [FIFO_CNT_W-1:0]     count_q, count_d;

  // Pointer and occupancy update; flush returns the FIFO to empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = ~wr_ptr_q;
      if (pop_i)  rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + FIFO_CNT_W'(push_i) - FIFO_CNT_W'(pop_i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; entries reset to a NOP at pc 0 so the head is defined out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '{pc: '0, instr: INSTR_NOP};
      end
    end else if (push_i && !flush_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues word reads to instruction
// memory (one-cycle read latency) and delivers {pc, instr} to decode through
// a 2-entry buffer. Execute may redirect the PC at any time.
//   clk, rst        : clock, asynchronous active-high reset
//   imem_req/addr   : read request and word address to instruction memory
//   imem_rdata      : instruction word, valid the cycle after a request
//   redirect_valid  : execute requests a PC change (highest priority)
//   redirect_pc     : new PC, low two bits ignored
//   id_valid/ready  : handshake toward decode
//   id_pc/id_instr  : head entry of the buffer
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr
);

  localparam int unsigned OCC_W = 3;
  localparam logic [XLEN-1:0] RESET_PC_ALIGNED = {RESET_PC[XLEN-1:2], 2'b00};

  logic [XLEN-1:0]       pc_q, pc_d;
  logic [XLEN-1:0]       tag_q, tag_d;
  logic                  inflight_q, inflight_d;
  logic [FIFO_CNT_W-1:0] fifo_count;
  fetch_entry_t          fifo_head;
  fetch_entry_t          push_entry;
  logic                  pop;
  logic                  push;
  logic                  issue;
  logic [OCC_W-1:0]      occupancy;

  // Only the word-aligned part of a redirect target is meaningful.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  assign id_valid = (fifo_count != '0) && !redirect_valid;
  assign pop      = id_valid && id_ready;
  assign push     = inflight_q && !redirect_valid;

  // Buffered plus in-flight entries; a same-cycle pop frees one slot.
  assign occupancy = OCC_W'(fifo_count) + OCC_W'(inflight_q);
  assign issue     = !rst && !redirect_valid
                   && (occupancy < (OCC_W'(2) + OCC_W'(pop)));

  assign imem_req  = issue;
  assign imem_addr = pc_q;

  // Next PC / in-flight tracking; redirect overrides issue.
  always_comb begin
    pc_d       = pc_q;
    tag_d      = tag_q;
    inflight_d = 1'b0;
    if (redirect_valid) begin
      pc_d = {redirect_pc[XLEN-1:2], 2'b00};
    end else if (issue) begin
      pc_d       = pc_q + XLEN'(4);
      tag_d      = pc_q;
      inflight_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC_ALIGNED;
      tag_q      <= RESET_PC_ALIGNED;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
    end
  end

  assign push_entry = '{pc: tag_q, instr: imem_rdata};

  fetch_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .count_o (fifo_count),
    .head_o  (fifo_head)
  );

  assign id_pc    = fifo_head.pc;
  assign id_instr = fifo_head.instr;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, fill/streaming, back-pressure,
// redirect, back-to-back redirect, PC wrap and asynchronous reset.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;

  int total;
  int bad;
  int nreq;

  fetch_stage #(.RESET_PC(32'h0000_1000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_pc          (id_pc),
    .id_instr       (id_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: word at address A is ~A, returned one cycle later.
  initial imem_rdata = 32'h0;
  always @(posedge clk) imem_rdata <= imem_req ? ~imem_addr : 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, apply inputs just after the edge, let logic settle.
  task automatic cyc(input logic rv, input logic [31:0] rpc, input logic rdy);
    @(posedge clk);
    #1;
    redirect_valid = rv;
    redirect_pc    = rpc;
    id_ready       = rdy;
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, 32'(id_valid), 32'd1);
    chk({tag, "_pc"}, id_pc, pc);
    chk({tag, "_instr"}, id_instr, ~pc);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1;
    id_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    #2;
    chk("rst_req",   32'(imem_req), 32'd0);
    chk("rst_addr",  imem_addr, 32'h0000_1000);
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_pc",    id_pc, 32'h0);
    chk("rst_instr", id_instr, 32'h0000_0013);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;

    // Startup and streaming with id_ready=1.
    chk("c0_req",   32'(imem_req), 32'd1);
    chk("c0_addr",  imem_addr, 32'h0000_1000);
    chk("c0_valid", 32'(id_valid), 32'd0);
    for (int c = 1; c <= 6; c++) begin
      cyc(1'b0, 32'h0, 1'b1);
      chk("st_req",  32'(imem_req), 32'd1);
      chk("st_addr", imem_addr, 32'h0000_1000 + 32'(4 * c));
      if (c >= 2) chk_head("st", 32'h0000_1000 + 32'(4 * (c - 2)));
      else        chk("st_valid0", 32'(id_valid), 32'd0);
    end

    // Back-pressure: buffer fills, head stays put.
    cyc(1'b0, 32'h0, 1'b0);
    chk("bp_req", 32'(imem_req), 32'd0);
    chk("bp_addr", imem_addr, 32'h0000_101C);
    chk_head("bp", 32'h0000_1014);
    for (int k = 0; k < 2; k++) begin
      cyc(1'b0, 32'h0, 1'b0);
      chk("bp_hold_req", 32'(imem_req), 32'd0);
      chk_head("bp_hold", 32'h0000_1014);
    end

    // Redirect with a full buffer; ready=1 must not pop.
    cyc(1'b1, 32'h0000_2003, 1'b1);
    chk("rd_valid", 32'(id_valid), 32'd0);
    chk("rd_req",   32'(imem_req), 32'd0);
    nreq = 0;
    for (int k = 1; k <= 6; k++) begin
      cyc(1'b0, 32'h0, 1'b0);
      nreq += int'(imem_req);
      if (k <= 2) begin
        chk("rd_req_new", 32'(imem_req), 32'd1);
        chk("rd_addr_new", imem_addr, 32'h0000_2000 + 32'(4 * (k - 1)));
        chk("rd_valid_fill", 32'(id_valid), 32'd0);
      end else begin
        chk("rd_addr_hold", imem_addr, 32'h0000_2008);
        chk_head("rd_head", 32'h0000_2000);
      end
    end
    chk("bp_nreq", 32'(nreq), 32'd2);
    for (int k = 7; k <= 10; k++) begin
      cyc(1'b0, 32'h0, 1'b1);
      chk_head("resume", 32'h0000_2000 + 32'(4 * (k - 7)));
    end

    // Back-to-back redirects: last one wins.
    cyc(1'b1, 32'h0000_3000, 1'b1);
    chk("bb1_req", 32'(imem_req), 32'd0);
    chk("bb1_valid", 32'(id_valid), 32'd0);
    cyc(1'b1, 32'h0000_4000, 1'b1);
    chk("bb2_req", 32'(imem_req), 32'd0);
    chk("bb2_valid", 32'(id_valid), 32'd0);
    cyc(1'b0, 32'h0, 1'b1);
    chk("bb_req", 32'(imem_req), 32'd1);
    chk("bb_addr", imem_addr, 32'h0000_4000);
    cyc(1'b0, 32'h0, 1'b1);
    chk("bb_addr2", imem_addr, 32'h0000_4004);
    chk("bb_valid", 32'(id_valid), 32'd0);
    cyc(1'b0, 32'h0, 1'b1);
    chk_head("bb_head", 32'h0000_4000);

    // PC wrap at the top of the address space.
    cyc(1'b1, 32'hFFFF_FFF8, 1'b1);
    cyc(1'b0, 32'h0, 1'b1);
    chk("wr_addr0", imem_addr, 32'hFFFF_FFF8);
    chk("wr_req0", 32'(imem_req), 32'd1);
    cyc(1'b0, 32'h0, 1'b1);
    chk("wr_addr1", imem_addr, 32'hFFFF_FFFC);
    chk("wr_req1", 32'(imem_req), 32'd1);
    cyc(1'b0, 32'h0, 1'b1);
    chk("wr_addr2", imem_addr, 32'h0000_0000);
    chk("wr_req2", 32'(imem_req), 32'd1);
    chk_head("wr_h0", 32'hFFFF_FFF8);
    cyc(1'b0, 32'h0, 1'b1);
    chk_head("wr_h1", 32'hFFFF_FFFC);
    cyc(1'b0, 32'h0, 1'b1);
    chk_head("wr_h2", 32'h0000_0000);

    // Fill the buffer, then assert reset mid-cycle.
    cyc(1'b0, 32'h0, 1'b0);
    chk("ar_req0", 32'(imem_req), 32'd0);
    cyc(1'b0, 32'h0, 1'b0);
    chk_head("ar_full", 32'h0000_0004);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_valid", 32'(id_valid), 32'd0);
    chk("ar_req",   32'(imem_req), 32'd0);
    chk("ar_addr",  imem_addr, 32'h0000_1000);
    chk("ar_pc",    id_pc, 32'h0);
    chk("ar_instr", id_instr, 32'h0000_0013);
    @(posedge clk);
    #1;
    rst = 1'b0;
    id_ready = 1'b1;
    #1;
    chk("ar_c0_req",  32'(imem_req), 32'd1);
    chk("ar_c0_addr", imem_addr, 32'h0000_1000);
    chk("ar_c0_valid", 32'(id_valid), 32'd0);
    cyc(1'b0, 32'h0, 1'b1);
    chk("ar_c1_addr", imem_addr, 32'h0000_1004);
    chk("ar_c1_valid", 32'(id_valid), 32'd0);
    cyc(1'b0, 32'h0, 1'b1);
    chk_head("ar_c2", 32'h0000_1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
